// File: rtl/melody_sequencer.sv
// Note-table sequencer driving the tone generator: plays host-written entries for a
// duration counted in accepted samples, with a fixed silent gap between notes.
module melody_sequencer #(
   parameter int DEPTH       = 16,
   parameter int GAP_SAMPLES = 480,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          sample_tick,
   output logic [3:0]    tone_note,
   output logic [2:0]    tone_octave,
   output logic [7:0]    tone_volume,
   output logic          tone_enable,
   output logic          tone_load,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] step_index
);

   localparam int GW = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_ADV} state_t;

   state_t        state_q, state_d;
   logic [31:0]   tbl_q [DEPTH];
   logic [31:0]   ent;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0]   dur_q, dur_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          last_q, last_d;
   logic [3:0]    note_q, note_d;
   logic [2:0]    oct_q, oct_d;
   logic [7:0]    vol_q, vol_d;
   logic          en_q, en_d, load_q, load_d, busy_q, busy_d, done_q, done_d;

   // Table survives reset so the host need not reload it.
   always_ff @(posedge clk) begin
      if (wr_en) tbl_q[wr_addr] <= wr_data;
   end

   assign ent = tbl_q[idx_q];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dur_d   = dur_q;
      gap_d   = gap_q;
      last_d  = last_q;
      note_d  = note_q;
      oct_d   = oct_q;
      vol_d   = vol_q;
      en_d    = en_q;
      load_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         en_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start && !stop) begin
               state_d = S_FETCH;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
            S_FETCH: begin
               last_d = ent[31];
               if (ent[15:0] == 16'd0) begin
                  state_d = S_ADV;
               end else begin
                  state_d = S_PLAY;
                  note_d  = ent[30:27];
                  oct_d   = ent[26:24];
                  vol_d   = ent[23:16];
                  dur_d   = ent[15:0];
                  load_d  = 1'b1;
                  // Notes 12..15 are rests: timed like a note but silent.
                  en_d    = (ent[30:27] <= 4'd11);
               end
            end
            S_PLAY: if (sample_tick) begin
               if (dur_q == 16'd1) begin
                  dur_d = '0;
                  en_d  = 1'b0;
                  if (GAP_SAMPLES == 0) begin
                     state_d = S_ADV;
                  end else begin
                     state_d = S_GAP;
                     gap_d   = GW'(GAP_SAMPLES);
                  end
               end else if (dur_q != 16'd0) begin
                  dur_d = dur_q - 16'd1;
               end
            end
            S_GAP: if (sample_tick) begin
               if (gap_q == GW'(1)) begin
                  gap_d   = '0;
                  state_d = S_ADV;
               end else if (gap_q != '0) begin
                  gap_d = gap_q - GW'(1);
               end
            end
            S_ADV: begin
               if (last_q || idx_q == AW'(DEPTH - 1)) begin
                  if (loop) begin
                     idx_d   = '0;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         dur_q   <= '0;
         gap_q   <= '0;
         last_q  <= 1'b0;
         note_q  <= '0;
         oct_q   <= '0;
         vol_q   <= '0;
         en_q    <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         vol_q   <= vol_d;
         en_q    <= en_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tone_note   = note_q;
   assign tone_octave = oct_q;
   assign tone_volume = vol_q;
   assign tone_enable = en_q;
   assign tone_load   = load_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign step_index  = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: expected load/done cycles and per-tick enable levels are
// derived from the note table as an event trace, with random tick spacing and tables.
module tb_melody_sequencer;
   localparam int DEPTH = 16;
   localparam int GAP   = 2;

   logic        clk = 1'b0, reset = 1'b1;
   logic        start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0, sample_tick = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  tone_note;
   logic [2:0]  tone_octave;
   logic [7:0]  tone_volume;
   logic        tone_enable, tone_load, busy, done;
   logic [3:0]  step_index;

   int checks = 0, errors = 0, cyc = 0, done_cnt = 0, tick_gap = 0;
   logic [31:0] tbl [DEPTH];

   melody_sequencer #(.DEPTH(DEPTH), .GAP_SAMPLES(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sample_tick(sample_tick),
      .tone_note(tone_note), .tone_octave(tone_octave), .tone_volume(tone_volume),
      .tone_enable(tone_enable), .tone_load(tone_load), .busy(busy), .done(done),
      .step_index(step_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   // Sample ticks arrive at random spacing, changing just after the active edge.
   initial forever begin
      @(posedge clk); #1;
      if (tick_gap == 0) begin
         sample_tick = 1'b1;
         tick_gap = $urandom_range(0, 3);
      end else begin
         sample_tick = 1'b0;
         tick_gap--;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input bit l, input int n, input int o, input int v, input int d);
      logic [31:0] e;
      e = {l, 4'(n), 3'(o), 8'(v), 16'(d)};
      return e;
   endfunction

   function automatic bit is_end(input int i);
      logic [31:0] e;
      e = tbl[i];
      return e[31] || i == DEPTH - 1;
   endfunction

   task automatic wr(input int a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; tbl[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_start(output int c0);
      @(negedge clk);
      start = 1'b1; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_load(output bit ok);
      int g = 0;
      while (tone_load !== 1'b1 && g < 400) begin
         @(negedge clk); g++;
      end
      ok = (tone_load === 1'b1);
      chk("load_seen", 32'(tone_load), 32'd1);
   endtask

   task automatic expect_done(input int c);
      int g = 0;
      while (cyc < c && g < 400) begin
         chk("no_early_done", 32'(done), 32'd0);
         @(negedge clk); g++;
      end
      chk("done_cycle", cyc, c);
      chk("done", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
   endtask

   // Walk the table the way playback should: skips cost two cycles each, a played
   // entry lasts dur+GAP counted ticks, then ADVANCE+FETCH before the next load.
   task automatic run_seq();
      int idx = 0, s = 0, t_last, c0, n, dur;
      bit ok;
      logic [31:0] e;
      pulse_start(c0);
      t_last = c0 - 1;
      chk("busy_after_start", 32'(busy), 32'd1);
      forever begin
         e = tbl[idx];
         if (e[15:0] == 16'd0) begin
            s++;
            if (is_end(idx)) begin
               expect_done(t_last + 2 + 2 * s);
               return;
            end
            idx++;
            continue;
         end
         wait_load(ok);
         if (!ok) begin
            do_stop();
            return;
         end
         chk("load_cycle", cyc - t_last, 3 + 2 * s);
         chk("fields", 32'({tone_note, tone_octave, tone_volume}), 32'(e[30:16]));
         chk("step_index", 32'(step_index), idx);
         dur = int'(e[15:0]);
         n = 0;
         while (n < dur + GAP) begin
            if (sample_tick) begin
               n++;
               chk("enable", 32'(tone_enable), 32'((n <= dur) && (e[30:27] <= 4'd11)));
               t_last = cyc;
            end
            if (n < dur + GAP) @(negedge clk);
         end
         s = 0;
         if (is_end(idx)) begin
            expect_done(t_last + 2);
            return;
         end
         idx++;
      end
   endtask

   initial begin
      int c0, dc;
      bit ok;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({tone_note, tone_octave, tone_volume, tone_enable, tone_load, busy, done, step_index}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Two-note single-shot.
      wr(0, mk(0, 9, 4, 10, 3));
      wr(1, mk(1, 0, 5, 20, 2));
      run_seq();

      // Looped playback, then stop while a note sounds.
      loop = 1'b1;
      dc = done_cnt;
      pulse_start(c0);
      wait_load(ok);
      chk("loop_n0", 32'({tone_note, tone_octave, tone_volume, step_index}), 32'({4'd9, 3'd4, 8'd10, 4'd0}));
      @(negedge clk);
      wait_load(ok);
      chk("loop_n1", 32'({tone_note, tone_octave, tone_volume, step_index}), 32'({4'd0, 3'd5, 8'd20, 4'd1}));
      @(negedge clk);
      wait_load(ok);
      chk("loop_restart", 32'({tone_note, tone_octave, tone_volume, step_index}), 32'({4'd9, 3'd4, 8'd10, 4'd0}));
      chk("loop_enable", 32'(tone_enable), 32'd1);
      do_stop();
      chk("stop_enable", 32'(tone_enable), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      loop = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_done_loop_stop", done_cnt, dc);

      // Zero-duration entry is skipped.
      wr(0, mk(0, 7, 1, 1, 0));
      wr(1, mk(1, 2, 3, 40, 1));
      run_seq();

      // Rest note.
      wr(0, mk(1, 13, 2, 55, 4));
      run_seq();

      // start and stop together from IDLE.
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("start_stop_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("start_stop_load", 32'(tone_load), 32'd0);

      // start during PLAY is ignored.
      wr(0, mk(1, 5, 3, 7, 8));
      pulse_start(c0);
      wait_load(ok);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_idx", 32'(step_index), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("restart_no_load", 32'(tone_load), 32'd0);
      chk("restart_enable", 32'(tone_enable), 32'd1);
      do_stop();

      // Reset mid-note, then replay from the retained table.
      pulse_start(c0);
      wait_load(ok);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_mid_play", 32'({tone_note, tone_octave, tone_volume, tone_enable, tone_load, busy, done, step_index}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_seq();

      // Random tables.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < DEPTH; i++)
            wr(i, mk($urandom_range(0, 4) == 0, $urandom_range(0, 15), $urandom_range(0, 7),
                     $urandom_range(0, 255), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5)));
         run_seq();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Sequencer that plays a programmable list of notes through the runtime-configurable tone generator in the audio path. It holds a 16-entry note table written by the host. On start it steps through the table, driving note, octave and volume to the tone generator for a duration counted in accepted audio samples, with a fixed silent gap between notes. Playback is single-shot or looped. It sits between the host/control register block and the tone generator feeding the 48 kHz codec sink.

## Interface
- DEPTH, 16: note table entries (power of two, index width clog2(DEPTH))
- GAP_SAMPLES, 480: silent samples inserted after every note (10 ms at 48 kHz); 0 = no gap
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; begin playback at entry 0
- stop  in  1  single-cycle pulse; abort playback
- loop  in  1  level; restart at entry 0 after the last entry instead of finishing
- wr_en  in  1  table write strobe
- wr_addr  in  clog2(DEPTH)  table write address
- wr_data  in  32  entry: [31] last, [30:27] note (0–11 = C..B), [26:24] octave, [23:16] volume, [15:0] duration in samples
- sample_tick  in  1  one pulse per sample accepted by the sink (sample_valid & sink_ready)
- tone_note  out  4  note index to the tone generator
- tone_octave  out  3  octave to the tone generator
- tone_volume  out  8  volume to the tone generator
- tone_enable  out  1  tone generator outputs non-zero samples while high
- tone_load  out  1  one-cycle pulse when new note/octave/volume are presented
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse on normal (non-looped, non-stopped) completion
- step_index  out  clog2(DEPTH)  table index currently playing

## Operation
- Table is a register array written on wr_en at any time, including while busy. It is not cleared by reset.
- A write to the entry being fetched in the same cycle: fetch sees the old contents.
- States:
  - IDLE: busy=0, tone_enable=0. start → FETCH with index 0.
  - FETCH (1 cycle): table[index] is read combinationally and fields are registered.
    - duration==0: entry is skipped → ADVANCE.
    - Otherwise → PLAY. tone_note/octave/volume are updated, tone_load pulses, and dur_cnt=duration.
    - tone_enable=1 only if note ≤ 11. Notes 12–15 are rests: the duration is still counted with tone_enable=0.
  - PLAY: each sample_tick decrements dur_cnt.
    - On the tick where dur_cnt==1: tone_enable→0, then → GAP with gap_cnt=GAP_SAMPLES.
    - If GAP_SAMPLES==0, go → ADVANCE instead.
  - GAP: each sample_tick decrements gap_cnt; on the tick where gap_cnt==1 → ADVANCE.
  - ADVANCE (1 cycle):
    - If the entry's last bit is set or index==DEPTH-1:
      - loop=1: index←0, → FETCH.
      - loop=0: → IDLE with a done pulse.
    - Otherwise index←index+1, → FETCH.
- stop in any non-IDLE state → IDLE on the next edge: tone_enable=0, busy=0, no done pulse.
- stop and start in the same cycle: stop wins.
- start while busy is ignored.
- sample_tick is ignored in IDLE, FETCH and ADVANCE.
- loop is sampled in ADVANCE only.
- Counters: dur_cnt 16 bit; gap_cnt sized for GAP_SAMPLES. Neither wraps, since the decrement happens only when the count is ≥1.

## Timing
- Reset values: tone_note=0, tone_octave=0, tone_volume=0, tone_enable=0, tone_load=0, busy=0, done=0, step_index=0; state IDLE; counters 0.
- All outputs are registered.
- start sampled at edge k: busy=1 after k. tone_load/tone_enable/step_index valid after edge k+1.
- Note length = exactly duration sample_ticks. tone_enable falls after the edge that samples the duration-th tick.
- Inter-note latency: last gap tick at edge m → next tone_load after edge m+2 (ADVANCE + FETCH).
- done is high for the cycle after the ADVANCE edge; busy falls on the same edge.
- Reset mid-playback: immediate return to IDLE with reset values; the table is retained.

## Test plan
- Write entries 0: {last=0, note=9, oct=4, vol=10, dur=3} and 1: {last=1, note=0, oct=5, vol=20, dur=2}. GAP_SAMPLES=2, tick every 4 cycles → tone_load twice with (9,4,10) then (0,5,20). tone_enable high for exactly 3 then 2 ticks, low for 2 gap ticks each. A single done pulse follows, then busy=0.
- Same table with loop=1 → after entry 1, step_index returns to 0 and tone_load repeats (9,4,10) with no done. stop pulse → tone_enable=0 and busy=0 on the next edge, no done.
- Entry 0 dur=0, entry 1 {last=1, note=2, dur=1} → entry 0 produces no tone_load; first tone_load shows note=2, step_index=1.
- Entry note=13, dur=4 → tone_load pulses with tone_enable=0 for 4 ticks; timing is identical to a played note.
- start and stop in the same cycle from IDLE → busy stays 0. start during PLAY → ignored, index unchanged.
- Assert reset during PLAY → all outputs 0 immediately. Deassert, then start → playback uses the retained table from entry 0.
